mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives a data-memory handshake with a wait/timeout FSM,
// detects misaligned accesses, resolves branches and registers MEM/WB.
module mem_stage #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] alu_result_memout,
  input  logic [63:0] adder_ex_out_mem_out,
  input  logic [63:0] mux_2_out_memout,
  input  logic [4:0]  rd_memout,
  input  logic        branch_exout_memout,
  input  logic        memread_exout_memout,
  input  logic        memwrite_exout_memout,
  input  logic        memtoreg_exout_memout,
  input  logic        regwrite_exout_memout,
  input  logic        zero_memout,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pcsrc,
  output logic [63:0] branch_target,
  output logic [63:0] read_data_wbout,
  output logic [63:0] alu_result_wbout,
  output logic [4:0]  rd_wbout,
  output logic        regwrite_wbout,
  output logic        memtoreg_wbout,
  output logic        err_timeout,
  output logic        err_misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;

  logic        w_memop;
  logic        w_misaligned;
  logic        w_req;
  logic        w_abort;
  logic        w_complete;
  logic        w_stall;
  logic        w_misalign_op;

  logic [63:0] r_read_data;
  logic [63:0] r_alu_result;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic        r_err_timeout;
  logic        r_err_misalign;

  assign w_memop      = memread_exout_memout | memwrite_exout_memout;
  assign w_misaligned = w_memop & (alu_result_memout[2:0] != 3'd0);

  // FSM state and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_memop && !w_misaligned && !dmem_ack) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_WAIT: begin
        if (dmem_ack || (r_cnt == TIMEOUT)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = 8'(r_cnt + 8'd1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Request is gated by reset so it drops the instant reset asserts
  always_comb begin
    w_req   = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:  w_req = w_memop & ~w_misaligned;
      S_WAIT: begin
        w_req   = 1'b1;
        w_abort = ~dmem_ack & (r_cnt == TIMEOUT);
      end
      default: w_req = 1'b0;
    endcase
    w_req         = w_req & ~reset;
    w_abort       = w_abort & ~reset;
    w_complete    = w_req & dmem_ack;
    w_stall       = w_req & ~dmem_ack & ~w_abort;
    w_misalign_op = (r_state == S_IDLE) & w_misaligned;
  end

  assign dmem_req      = w_req;
  assign dmem_we       = w_req & memwrite_exout_memout;
  assign dmem_addr     = w_req ? alu_result_memout : 64'd0;
  assign dmem_wdata    = w_req ? mux_2_out_memout : 64'd0;
  assign stall         = w_stall;
  assign pcsrc         = branch_exout_memout & zero_memout;
  assign branch_target = adder_ex_out_mem_out;

  // MEM/WB register and sticky error flags; stall, abort and misalign all bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data    <= 64'd0;
      r_alu_result   <= 64'd0;
      r_rd           <= 5'd0;
      r_regwrite     <= 1'b0;
      r_memtoreg     <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_misalign <= 1'b0;
    end else begin
      if (w_abort)       r_err_timeout  <= 1'b1;
      if (w_misalign_op) r_err_misalign <= 1'b1;
      if (w_stall || w_abort || w_misalign_op) begin
        r_regwrite <= 1'b0;
        r_memtoreg <= 1'b0;
      end else begin
        r_alu_result <= alu_result_memout;
        r_rd         <= rd_memout;
        r_regwrite   <= regwrite_exout_memout;
        r_memtoreg   <= memtoreg_exout_memout;
        if (w_complete && memread_exout_memout && !memwrite_exout_memout)
          r_read_data <= dmem_rdata;
      end
    end
  end

  assign read_data_wbout  = r_read_data;
  assign alu_result_wbout = r_alu_result;
  assign rd_wbout         = r_rd;
  assign regwrite_wbout   = r_regwrite;
  assign memtoreg_wbout   = r_memtoreg;
  assign err_timeout      = r_err_timeout;
  assign err_misalign     = r_err_misalign;

endmodule
